// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and its datapath/memory.
// The controller side (master) receives the opcode and the memory
// handshake, and drives the per-state control word.
interface multicycle_control_if;
  logic [5:0] instr_op_i;
  logic       mem_ready_i;
  logic       PCWrite_o;
  logic       PCWriteCond_o;
  logic       BranchType_o;
  logic       IorD_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       IRWrite_o;
  logic [1:0] MemToReg_o;
  logic [1:0] RegDst_o;
  logic       RegWrite_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [2:0] ALU_op_o;
  logic [1:0] PCSource_o;
  logic [3:0] state_o;
  logic       instr_done_o;
  logic       illegal_o;
  logic       bus_err_o;

  modport master (
    input  instr_op_i, mem_ready_i,
    output PCWrite_o, PCWriteCond_o, BranchType_o, IorD_o, MemRead_o, MemWrite_o,
           IRWrite_o, MemToReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o,
           ALU_op_o, PCSource_o, state_o, instr_done_o, illegal_o, bus_err_o
  );

  modport slave (
    output instr_op_i, mem_ready_i,
    input  PCWrite_o, PCWriteCond_o, BranchType_o, IorD_o, MemRead_o, MemWrite_o,
           IRWrite_o, MemToReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o,
           ALU_op_o, PCSource_o, state_o, instr_done_o, illegal_o, bus_err_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle MIPS datapath sharing one
// instruction/data memory. Memory states wait on mem_ready_i with an
// optional timeout that aborts the instruction and returns to fetch.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input logic                  clk_i,
  input logic                  rst_i,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StIExec    = 4'd10,
    StIWb      = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_type;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;
  } ctrl_t;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpOri   = 6'b001101;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mem_state;
  logic               timeout;
  logic               ready;
  logic [5:0]         op;
  ctrl_t              ctrl;

  assign ready = bus.mem_ready_i;
  assign op    = bus.instr_op_i;

  // Memory-wait bookkeeping: timeout fires only when ready is still low.
  always_comb begin
    mem_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
    timeout   = (MEM_TIMEOUT != 0) && mem_state && !ready && (wait_cnt_q == CntLast);
  end

  // Wait counter: counts stalled cycles, cleared on any state change.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_state && !ready && !timeout) begin
      // Saturate so a disabled timeout never wraps into a false count.
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  // State and wait counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and per-state control word; everything forced low in reset.
  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = 3'b100;
        ctrl.ir_write  = ready;
        ctrl.pc_write  = ready;
        if (ready) begin
          state_d = StDecode;
        end else if (timeout) begin
          ctrl.bus_err = 1'b1;
          state_d      = StFetch;
        end
      end
      StDecode: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = 3'b100;
        case (op)
          OpRtype:                          state_d = StRExec;
          OpLw, OpSw:                       state_d = StMemAddr;
          OpBeq, OpBne:                     state_d = StBranch;
          OpJ, OpJal:                       state_d = StJump;
          OpAddi, OpSltiu, OpLui, OpOri:    state_d = StIExec;
          default: begin
            ctrl.illegal    = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = 3'b100;
        state_d        = (op == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          ctrl.bus_err = 1'b1;
          state_d      = StFetch;
        end
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 2'b01;
        ctrl.instr_done = 1'b1;
        state_d         = StFetch;
      end
      StMemWrite: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (ready) begin
          ctrl.instr_done = 1'b1;
          state_d         = StFetch;
        end else if (timeout) begin
          ctrl.bus_err = 1'b1;
          state_d      = StFetch;
        end
      end
      StRExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 3'b010;
        state_d        = StRWb;
      end
      StRWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 2'b01;
        ctrl.instr_done = 1'b1;
        state_d         = StFetch;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        ctrl.instr_done    = 1'b1;
        ctrl.branch_type   = (op == OpBne);
        ctrl.alu_op        = (op == OpBne) ? 3'b001 : 3'b011;
        state_d            = StFetch;
      end
      StJump: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = 2'b10;
        ctrl.instr_done = 1'b1;
        if (op == OpJal) begin
          // PC already holds PC+4 from fetch, so it is the link value.
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 2'b10;
          ctrl.mem_to_reg = 2'b10;
        end
        state_d = StFetch;
      end
      StIExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        case (op)
          OpSltiu: ctrl.alu_op = 3'b111;
          OpLui:   ctrl.alu_op = 3'b101;
          OpOri:   ctrl.alu_op = 3'b110;
          default: ctrl.alu_op = 3'b100;
        endcase
        state_d = StIWb;
      end
      StIWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = StFetch;
      end
      default: state_d = StFetch;
    endcase
    if (!rst_i) begin
      ctrl = '0;
    end
  end

  assign bus.PCWrite_o     = ctrl.pc_write;
  assign bus.PCWriteCond_o = ctrl.pc_write_cond;
  assign bus.BranchType_o  = ctrl.branch_type;
  assign bus.IorD_o        = ctrl.i_or_d;
  assign bus.MemRead_o     = ctrl.mem_read;
  assign bus.MemWrite_o    = ctrl.mem_write;
  assign bus.IRWrite_o     = ctrl.ir_write;
  assign bus.MemToReg_o    = ctrl.mem_to_reg;
  assign bus.RegDst_o      = ctrl.reg_dst;
  assign bus.RegWrite_o    = ctrl.reg_write;
  assign bus.ALUSrcA_o     = ctrl.alu_src_a;
  assign bus.ALUSrcB_o     = ctrl.alu_src_b;
  assign bus.ALU_op_o      = ctrl.alu_op;
  assign bus.PCSource_o    = ctrl.pc_source;
  assign bus.instr_done_o  = ctrl.instr_done;
  assign bus.illegal_o     = ctrl.illegal;
  assign bus.bus_err_o     = ctrl.bus_err;
  assign bus.state_o       = rst_i ? state_q : 4'd0;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM controller that sequences a multi-cycle MIPS datapath over a shared instruction/data memory.
- Replaces the per-instruction combinational decode with per-state control words.
- Waits on a variable-latency memory handshake and has a wait timeout.
- Decodes opcode from the instruction register; funct-level ALU decode stays downstream (ALU_op_o 010).

Parameters:
MEM_TIMEOUT, 16, max cycles spent in one memory state waiting for mem_ready_i; 0 disables timeout
CNT_W, 5, width of wait counter; must hold MEM_TIMEOUT-1

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-low
instr_op_i  in  6  opcode, IR[31:26]
mem_ready_i  in  1  memory completes current read/write this cycle
PCWrite_o  out  1  unconditional PC load
PCWriteCond_o  out  1  PC load if branch condition true
BranchType_o  out  1  0=beq (zero), 1=bne (!zero)
IorD_o  out  1  memory address: 0=PC, 1=ALUOut
MemRead_o  out  1  memory read request
MemWrite_o  out  1  memory write request
IRWrite_o  out  1  load IR
MemToReg_o  out  2  00=ALUOut, 01=MDR, 10=PC (jal link)
RegDst_o  out  2  00=rt, 01=rd, 10=$31
RegWrite_o  out  1  register file write
ALUSrcA_o  out  1  0=PC, 1=rs
ALUSrcB_o  out  2  00=rt, 01=const 4, 10=sign/zero-ext imm, 11=imm<<2
ALU_op_o  out  3  010 R-type, 100 add, 011 beq-sub, 001 bne-sub, 111 sltiu, 101 lui, 110 ori
PCSource_o  out  2  00=ALU result, 01=ALUOut, 10=jump target
state_o  out  4  current state, debug
instr_done_o  out  1  one-cycle pulse in the last cycle of each instruction
illegal_o  out  1  one-cycle pulse on undefined opcode
bus_err_o  out  1  one-cycle pulse on memory timeout

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11
- Reset: while rst_i=0 at a clock edge, state<=FETCH and wait_cnt<=0. All outputs are combinationally forced to 0 while rst_i=0 (state_o reads 0). A reset mid-instruction aborts it; no partial write occurs after reset is sampled.
- FETCH:
  - Asserts MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=100, PCSource=00.
  - IRWrite and PCWrite are asserted only in a cycle where mem_ready_i=1 (ANDed with mem_ready_i).
  - On mem_ready_i=1 go to DECODE; otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=100 (branch target). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000100 or 000101 -> BRANCH
  - 000010 or 000011 -> JUMP
  - 001000, 001011, 001111, 001101 -> I_EXEC
  - any other opcode -> FETCH with illegal_o=1 and instr_done_o=1
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_op=100. Next is MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: MemRead=1, IorD=1. On mem_ready_i go to MEM_WB.
- MEM_WB: RegWrite=1, RegDst=00, MemToReg=01, instr_done=1. Next FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. On mem_ready_i, instr_done=1 and go to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALU_op=010. Next R_WB.
- R_WB: RegWrite=1, RegDst=01, MemToReg=00, instr_done=1. Next FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, PCWriteCond=1, PCSource=01, instr_done=1. Next FETCH.
  - beq: ALU_op=011, BranchType=0. bne: ALU_op=001, BranchType=1.
- JUMP:
  - PCWrite=1, PCSource=10, instr_done=1. Next FETCH.
  - jal additionally: RegWrite=1, RegDst=10, MemToReg=10; PC already holds PC+4.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALU_op = 100 addi / 111 sltiu / 101 lui / 110 ori. Next I_WB.
- I_WB: RegWrite=1, RegDst=00, MemToReg=00, instr_done=1. Next FETCH.
- Any output not listed for a state is 0.
- Memory wait (FETCH, MEM_READ, MEM_WRITE):
  - wait_cnt clears on entry to a memory state and increments each cycle mem_ready_i=0.
  - If mem_ready_i=0 and wait_cnt==MEM_TIMEOUT-1 (MEM_TIMEOUT≠0): bus_err_o=1, next FETCH, no IRWrite/PCWrite/RegWrite.
  - Completion wins: mem_ready_i=1 in the final allowed cycle completes normally with no error.
- Zero-wait latencies: R/I-type 4 cycles, lw 5, sw 4, beq/bne/j/jal 3.
- Opcode is sampled in DECODE and in state-dependent branches thereafter. IR is stable because IRWrite is only asserted in FETCH.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles mid-R_EXEC, then release -> all outputs 0 during reset; state_o=0, MemRead_o=1 the cycle after release.
- R-type (op 000000), mem_ready_i tied 1 -> state_o sequence 0,1,6,7,0; RegWrite_o=1 and RegDst_o=01 only in state 7; instr_done_o once per instruction.
- lw (100011) with mem_ready_i low 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0; MemRead_o=1 and IorD_o=1 throughout state 3; MemToReg_o=01 in state 4.
- bne (000101) -> state 8 with PCWriteCond_o=1, BranchType_o=1, ALU_op_o=001, PCSource_o=01, then 0; jal (000011) -> state 9 with PCWrite_o=1, RegWrite_o=1, RegDst_o=10, MemToReg_o=10.
- Opcode 111111 -> DECODE returns to FETCH with illegal_o=1 for exactly one cycle and RegWrite_o=0.
- mem_ready_i held 0 in FETCH, MEM_TIMEOUT=16 -> bus_err_o pulses in the 16th FETCH cycle, IRWrite_o never 1, FETCH re-entered with wait_cnt=0; repeat with ready in cycle 16 -> no error, DECODE.
